// File: rtl/decoder_pkg.sv
// Shared types, mode encodings and the one-hot helper for the sequenced decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT   = 256;

  // One-hot of sel over n lines; all zero when sel is outside 0..n-1 (unsigned compare).
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                input int unsigned n);
    onehot = '0;
    if (32'(sel) < n) onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_pulse_cnt.sv
// Loadable down-counter timing pulse-mode outputs; term_c flags the last pulse cycle (cnt==1).
module decoder_pulse_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             term_c
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over load, load over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign term_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input, level/pulse modes and range check.
// Optional latched error (err_clr/err_sticky) built when DEC_ERR_STICKY_EN is defined.
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W      = 3,
  parameter int unsigned NUM_OUT   = 8,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_sel,
  input  logic               in_mode,
  output logic [NUM_OUT-1:0] out,
  output logic               err,
  output logic               busy
`ifdef DEC_ERR_STICKY_EN
  ,
  input  logic               err_clr,
  output logic               err_sticky
`endif
);

  localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               in_range;
  logic               term;
  logic [NUM_OUT-1:0] out_nxt;
  logic               err_nxt;
  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_dec;

  // Ready on the final pulse cycle too, so back-to-back pulses leave no gap.
  assign in_ready = en & ((state != PULSE) | term);
  assign accept   = in_valid & in_ready;
  assign in_range = (32'(in_sel) < NUM_OUT);

  decoder_pulse_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (CNT_W'(PULSE_LEN)),
    .dec      (cnt_dec),
    .term_c   (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else if (accept) begin
      if (!in_range)                   state_nxt = IDLE;
      else if (in_mode == MODE_PULSE)  state_nxt = PULSE;
      else                             state_nxt = HOLD;
    end else if ((state == PULSE) && term) begin
      state_nxt = IDLE;
    end
  end

  // Next values for the output register and counter controls.
  always_comb begin
    out_nxt  = out;
    err_nxt  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (!en) begin
      out_nxt = '0;
      cnt_clr = 1'b1;
    end else if (accept) begin
      out_nxt  = in_range ? NUM_OUT'(onehot(MAX_SEL_W'(in_sel), NUM_OUT)) : '0;
      err_nxt  = ~in_range;
      cnt_load = in_range & (in_mode == MODE_PULSE);
      cnt_clr  = ~cnt_load;
    end else if (state == PULSE) begin
      cnt_dec = 1'b1;
      if (term) out_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      err  <= 1'b0;
      busy <= 1'b0;
    end else begin
      out  <= out_nxt;
      err  <= err_nxt;
      busy <= (state_nxt == PULSE);
    end
  end

`ifdef DEC_ERR_STICKY_EN
  // An error being flagged or about to be flagged overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_sticky <= 1'b0;
    else if (err_nxt || err)   err_sticky <= 1'b1;
    else if (err_clr)          err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Scoreboard bench: instance A (NUM_OUT=6, PULSE_LEN=4) and instance B (NUM_OUT=8, PULSE_LEN=1).
// Sticky-error checks compiled in when DEC_ERR_STICKY_EN is defined.
module tb_decoder_onehot_seq;

  localparam int unsigned IN_W = 3;
  localparam int unsigned NA   = 6;
  localparam int unsigned NB   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            en_a, valid_a, mode_a, ready_a, err_a, busy_a;
  logic [IN_W-1:0] sel_a;
  logic [NA-1:0]   out_a;
  logic            en_b, valid_b, mode_b, ready_b, err_b, busy_b;
  logic [IN_W-1:0] sel_b;
  logic [NB-1:0]   out_b;
`ifdef DEC_ERR_STICKY_EN
  logic clr_a, stk_a, clr_b, stk_b;
`endif

  typedef struct {
    logic [7:0] out;
    logic       err;
    logic       busy;
    logic       rdy;
    logic       stk;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t xa, xb;
  int   n_checks = 0;
  int   n_fail   = 0;

  decoder_onehot_seq #(.IN_W(IN_W), .NUM_OUT(NA), .PULSE_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_sel(sel_a), .in_mode(mode_a), .out(out_a), .err(err_a), .busy(busy_a)
`ifdef DEC_ERR_STICKY_EN
    , .err_clr(clr_a), .err_sticky(stk_a)
`endif
  );

  decoder_onehot_seq #(.IN_W(IN_W), .NUM_OUT(NB), .PULSE_LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_sel(sel_b), .in_mode(mode_b), .out(out_b), .err(err_b), .busy(busy_b)
`ifdef DEC_ERR_STICKY_EN
    , .err_clr(clr_b), .err_sticky(stk_b)
`endif
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Row = inputs for one cycle plus outputs expected to be visible in that same cycle.
  task automatic row_a(input logic e, input logic v, input int s, input logic m, input logic c,
                       input logic [7:0] eo, input logic ee, input logic eb, input logic er,
                       input logic es);
    @(posedge clk); #1;
    en_a = e; valid_a = v; sel_a = IN_W'(s); mode_a = m;
`ifdef DEC_ERR_STICKY_EN
    clr_a = c;
`else
    if (c) begin end
`endif
    qa.push_back('{eo, ee, eb, er, es});
  endtask

  task automatic row_b(input logic v, input int s, input logic [7:0] eo, input logic eb);
    @(posedge clk); #1;
    valid_b = v; sel_b = IN_W'(s);
    qb.push_back('{eo, 1'b0, eb, 1'b1, 1'b0});
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (qa.size() + qb.size()) > 0; i++) begin
      @(negedge clk); #1;
    end
    if ((qa.size() + qb.size()) > 0) check("drain_timeout", 8'(qa.size() + qb.size()), 8'd0);
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      xa = qa.pop_front();
      check("a_out", 8'(out_a), xa.out);
      check("a_err", 8'(err_a), 8'(xa.err));
      check("a_busy", 8'(busy_a), 8'(xa.busy));
      check("a_ready", 8'(ready_a), 8'(xa.rdy));
`ifdef DEC_ERR_STICKY_EN
      check("a_sticky", 8'(stk_a), 8'(xa.stk));
`endif
    end
  end

  always @(negedge clk) begin
    if (qb.size() > 0) begin
      xb = qb.pop_front();
      check("b_out", 8'(out_b), xb.out);
      check("b_err", 8'(err_b), 8'(xb.err));
      check("b_busy", 8'(busy_b), 8'(xb.busy));
      check("b_ready", 8'(ready_b), 8'(xb.rdy));
`ifdef DEC_ERR_STICKY_EN
      check("b_sticky", 8'(stk_b), 8'(xb.stk));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    en_a = 1'b1; valid_a = 1'b0; sel_a = '0; mode_a = 1'b0;
    en_b = 1'b1; valid_b = 1'b0; sel_b = '0; mode_b = 1'b1;
`ifdef DEC_ERR_STICKY_EN
    clr_a = 1'b0; clr_b = 1'b0;
`endif
    #12;
    check("rst_out", 8'(out_a), 8'h00);
    check("rst_err", 8'(err_a), 8'h00);
    check("rst_busy", 8'(busy_a), 8'h00);
    check("rst_ready", 8'(ready_a), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;

    // e  v  s  m  c |  out  err busy rdy stk
    row_a(1, 1, 5, 0, 0, 8'h00, 0, 0, 1, 0);
    row_a(1, 1, 0, 0, 0, 8'h20, 0, 0, 1, 0);
    row_a(1, 0, 0, 0, 0, 8'h01, 0, 0, 1, 0);
    row_a(1, 0, 0, 0, 0, 8'h01, 0, 0, 1, 0);
    row_a(1, 1, 2, 1, 0, 8'h01, 0, 0, 1, 0);
    row_a(1, 1, 3, 1, 0, 8'h04, 0, 1, 0, 0);
    row_a(1, 1, 3, 1, 0, 8'h04, 0, 1, 0, 0);
    row_a(1, 1, 3, 1, 0, 8'h04, 0, 1, 0, 0);
    row_a(1, 1, 3, 1, 0, 8'h04, 0, 1, 1, 0);
    row_a(1, 0, 0, 0, 0, 8'h08, 0, 1, 0, 0);
    row_a(0, 0, 0, 0, 0, 8'h08, 0, 1, 0, 0);
    row_a(0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    row_a(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    row_a(1, 1, 6, 0, 0, 8'h00, 0, 0, 1, 0);
    row_a(1, 1, 7, 1, 1, 8'h00, 1, 0, 1, 1);
    row_a(1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 1);
    row_a(1, 1, 4, 0, 1, 8'h00, 0, 0, 1, 1);
    row_a(1, 1, 6, 0, 0, 8'h10, 0, 0, 1, 0);
    row_a(1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 1);
    row_a(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1);
    row_a(1, 1, 1, 1, 0, 8'h00, 0, 0, 1, 1);
    row_a(1, 0, 0, 0, 0, 8'h02, 0, 1, 0, 1);
    row_a(1, 0, 0, 0, 0, 8'h02, 0, 1, 0, 1);
    row_a(1, 0, 0, 0, 0, 8'h02, 0, 1, 0, 1);
    row_a(1, 0, 0, 0, 0, 8'h02, 0, 1, 1, 1);
    row_a(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1);
    row_a(1, 1, 4, 1, 0, 8'h00, 0, 0, 1, 1);
    row_a(1, 0, 0, 0, 0, 8'h10, 0, 1, 0, 1);
    drain();

    // Asynchronous reset in the middle of a pulse.
    @(posedge clk); #2;
    check("pre_rst_busy", 8'(busy_a), 8'h01);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 8'(out_a), 8'h00);
    check("async_rst_busy", 8'(busy_a), 8'h00);
    check("async_rst_err", 8'(err_a), 8'h00);
`ifdef DEC_ERR_STICKY_EN
    check("async_rst_sticky", 8'(stk_a), 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 8'(ready_a), 8'h01);

    // Single-cycle strobes streamed back to back: one-hot walks one bit per cycle.
    for (int k = 0; k < 8; k++) begin
      row_b(1'b1, k, (k == 0) ? 8'h00 : 8'(1 << (k - 1)), (k != 0));
    end
    row_b(1'b0, 0, 8'h80, 1'b1);
    row_b(1'b0, 0, 8'h00, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
